// File: rtl/btb_port_arbiter_pkg.sv
// Shared types and constants for the BTB/BP port arbiter and its update queue.
package btb_port_arbiter_pkg;

  localparam int BR_W             = 24;
  localparam int ADDR_W           = 32;
  localparam int LHT_W            = 5;
  localparam int QDEPTH_DEF       = 4;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LKP  = 2'd1,
    UPD  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [BR_W-1:0]   inst;
    logic [ADDR_W-1:0] taddr;
    logic              taken;
    logic              cond;
  } upd_entry_t;

  // The local-history table is indexed by the low bits of instruction[31:8].
  function automatic logic [LHT_W-1:0] lht_index(input logic [BR_W-1:0] inst);
    return inst[LHT_W-1:0];
  endfunction

endpackage

// File: rtl/btb_port_arbiter_if.sv
// Fetch/execute request side and BTB/BP port side of the arbiter, bundled.
interface btb_port_arbiter_if #(
  parameter int QDEPTH = btb_port_arbiter_pkg::QDEPTH_DEF
) ();
  import btb_port_arbiter_pkg::*;

  logic                 lkp_req;
  logic [BR_W-1:0]      lkp_inst;
  logic                 lkp_cond;
  logic                 lkp_gnt;

  logic                 upd_valid;
  logic [BR_W-1:0]      upd_inst;
  logic [ADDR_W-1:0]    upd_taddr;
  logic                 upd_taken;
  logic                 upd_cond;
  logic                 upd_ready;

  logic                 btb_rd_wr;
  logic                 btb_sel;
  logic [BR_W-1:0]      btb_inst;
  logic [ADDR_W-1:0]    btb_taddr;

  logic                 bp_rd_wr;
  logic                 bp_sel;
  logic [LHT_W-1:0]     bp_lht_index;
  logic                 bp_taken;

  logic [$clog2(QDEPTH):0] q_count;

  modport master (
    output lkp_req, lkp_inst, lkp_cond,
    output upd_valid, upd_inst, upd_taddr, upd_taken, upd_cond,
    input  lkp_gnt, upd_ready,
    input  btb_rd_wr, btb_sel, btb_inst, btb_taddr,
    input  bp_rd_wr, bp_sel, bp_lht_index, bp_taken,
    input  q_count
  );

  modport slave (
    input  lkp_req, lkp_inst, lkp_cond,
    input  upd_valid, upd_inst, upd_taddr, upd_taken, upd_cond,
    output lkp_gnt, upd_ready,
    output btb_rd_wr, btb_sel, btb_inst, btb_taddr,
    output bp_rd_wr, bp_sel, bp_lht_index, bp_taken,
    output q_count
  );

endinterface

// File: rtl/btb_update_fifo.sv
// Resolved-branch update queue: circular buffer, push is dropped when full.
module btb_update_fifo import btb_port_arbiter_pkg::*; #(
  parameter  int DEPTH = QDEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  upd_entry_t       din,
  output upd_entry_t       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  upd_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale slots are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/btb_port_arbiter.sv
// Shares one BTB/BP port between fetch lookups and queued execute-stage updates.
module btb_port_arbiter import btb_port_arbiter_pkg::*; #(
  parameter int QDEPTH       = QDEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst,
  btb_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int SV_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SV_W-1:0] STARVE_MAX = SV_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [SV_W-1:0]   starve_q, starve_d;

  logic              lkp_gnt_q, lkp_gnt_d;
  logic              btb_rd_wr_q, btb_rd_wr_d;
  logic              btb_sel_q, btb_sel_d;
  logic [BR_W-1:0]   btb_inst_q, btb_inst_d;
  logic [ADDR_W-1:0] btb_taddr_q, btb_taddr_d;
  logic              bp_rd_wr_q, bp_rd_wr_d;
  logic              bp_sel_q, bp_sel_d;
  logic [LHT_W-1:0]  bp_lht_index_q, bp_lht_index_d;
  logic              bp_taken_q, bp_taken_d;

  upd_entry_t        push_entry;
  upd_entry_t        head;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic [CNT_W-1:0]  q_cnt;

  always_comb begin
    push_entry       = '0;
    push_entry.inst  = bus.upd_inst;
    push_entry.taddr = bus.upd_taddr;
    push_entry.taken = bus.upd_taken;
    push_entry.cond  = bus.upd_cond;
  end

  assign bus.upd_ready = rst && !q_full;
  assign q_push        = bus.upd_valid && bus.upd_ready;
  assign q_pop         = (state_d == UPD);

  btb_update_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (push_entry),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  // Arbitration looks only at pre-edge queue state; a fresh push cannot issue this edge.
  always_comb begin
    state_d = IDLE;
    if (!q_empty && (q_full || !bus.lkp_req || starve_q == STARVE_MAX)) state_d = UPD;
    else if (bus.lkp_req)                                                state_d = LKP;

    starve_d = '0;
    if (state_d == LKP && !q_empty)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SV_W'(1);

    lkp_gnt_d      = 1'b0;
    btb_rd_wr_d    = 1'b1;
    btb_sel_d      = 1'b0;
    btb_inst_d     = '0;
    btb_taddr_d    = '0;
    bp_rd_wr_d     = 1'b1;
    bp_sel_d       = 1'b0;
    bp_lht_index_d = '0;
    bp_taken_d     = 1'b0;

    case (state_d)
      LKP: begin
        lkp_gnt_d      = 1'b1;
        btb_sel_d      = 1'b1;
        btb_inst_d     = bus.lkp_inst;
        bp_sel_d       = bus.lkp_cond;
        bp_lht_index_d = lht_index(bus.lkp_inst);
      end
      UPD: begin
        btb_sel_d      = 1'b1;
        btb_rd_wr_d    = 1'b0;
        btb_inst_d     = head.inst;
        btb_taddr_d    = head.taddr;
        bp_sel_d       = head.cond;
        bp_rd_wr_d     = 1'b0;
        bp_lht_index_d = lht_index(head.inst);
        bp_taken_d     = head.taken;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      lkp_gnt_q      <= 1'b0;
      btb_rd_wr_q    <= 1'b1;
      btb_sel_q      <= 1'b0;
      btb_inst_q     <= '0;
      btb_taddr_q    <= '0;
      bp_rd_wr_q     <= 1'b1;
      bp_sel_q       <= 1'b0;
      bp_lht_index_q <= '0;
      bp_taken_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      lkp_gnt_q      <= lkp_gnt_d;
      btb_rd_wr_q    <= btb_rd_wr_d;
      btb_sel_q      <= btb_sel_d;
      btb_inst_q     <= btb_inst_d;
      btb_taddr_q    <= btb_taddr_d;
      bp_rd_wr_q     <= bp_rd_wr_d;
      bp_sel_q       <= bp_sel_d;
      bp_lht_index_q <= bp_lht_index_d;
      bp_taken_q     <= bp_taken_d;
    end
  end

  assign bus.lkp_gnt      = lkp_gnt_q;
  assign bus.btb_rd_wr    = btb_rd_wr_q;
  assign bus.btb_sel      = btb_sel_q;
  assign bus.btb_inst     = btb_inst_q;
  assign bus.btb_taddr    = btb_taddr_q;
  assign bus.bp_rd_wr     = bp_rd_wr_q;
  assign bus.bp_sel       = bp_sel_q;
  assign bus.bp_lht_index = bp_lht_index_q;
  assign bus.bp_taken     = bp_taken_q;
  assign bus.q_count      = q_cnt;

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Randomized bench for btb_port_arbiter with a queue-based reference model and directed pins.
module tb_btb_port_arbiter;
  import btb_port_arbiter_pkg::*;

  localparam int QD = 4;
  localparam int SL = 3;

  typedef struct packed {
    logic              lkp_gnt;
    logic              btb_sel;
    logic              btb_rd_wr;
    logic [BR_W-1:0]   btb_inst;
    logic [ADDR_W-1:0] btb_taddr;
    logic              bp_sel;
    logic              bp_rd_wr;
    logic [LHT_W-1:0]  bp_lht_index;
    logic              bp_taken;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btb_port_arbiter_if #(.QDEPTH(QD)) bus ();

  btb_port_arbiter #(
    .QDEPTH       (QD),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.btb_rd_wr = 1'b1;
    o.bp_rd_wr  = 1'b1;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.lkp_gnt      = bus.lkp_gnt;
    o.btb_sel      = bus.btb_sel;
    o.btb_rd_wr    = bus.btb_rd_wr;
    o.btb_inst     = bus.btb_inst;
    o.btb_taddr    = bus.btb_taddr;
    o.bp_sel       = bus.bp_sel;
    o.bp_rd_wr     = bus.bp_rd_wr;
    o.bp_lht_index = bus.bp_lht_index;
    o.bp_taken     = bus.bp_taken;
    return o;
  endfunction

  // Reference: a plain queue of pending updates plus a count of lookups won while work waits.
  upd_entry_t mq[$];
  int         mstarve = 0;
  out_t       mexp;

  task automatic model_step();
    upd_entry_t e;
    bit nonempty;
    bit isfull;
    if (!rst) begin
      mq.delete();
      mstarve = 0;
      mexp = idle_out();
      return;
    end
    nonempty = (mq.size() > 0);
    isfull   = (mq.size() == QD);
    if (nonempty && (isfull || !bus.lkp_req || mstarve == SL)) begin
      e = mq.pop_front();
      mexp = '0;
      mexp.btb_sel      = 1'b1;
      mexp.btb_inst     = e.inst;
      mexp.btb_taddr    = e.taddr;
      mexp.bp_sel       = e.cond;
      mexp.bp_lht_index = e.inst[4:0];
      mexp.bp_taken     = e.taken;
      mstarve = 0;
    end else if (bus.lkp_req) begin
      mexp = '0;
      mexp.lkp_gnt      = 1'b1;
      mexp.btb_sel      = 1'b1;
      mexp.btb_rd_wr    = 1'b1;
      mexp.btb_inst     = bus.lkp_inst;
      mexp.bp_sel       = bus.lkp_cond;
      mexp.bp_rd_wr     = 1'b1;
      mexp.bp_lht_index = bus.lkp_inst[4:0];
      mstarve = nonempty ? ((mstarve < SL) ? mstarve + 1 : SL) : 0;
    end else begin
      mexp = idle_out();
      mstarve = 0;
    end
    if (bus.upd_valid && !isfull) begin
      e.inst  = bus.upd_inst;
      e.taddr = bus.upd_taddr;
      e.taken = bus.upd_taken;
      e.cond  = bus.upd_cond;
      mq.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (!done) begin
      model_step();
      #1;
      cyc++;
      chk("outs", dut_out(), mexp);
      chk("q_count", bus.q_count, mq.size());
      chk("upd_ready", bus.upd_ready, (rst && mq.size() != QD));
    end
  end

  task automatic clr_inputs();
    bus.lkp_req   = 1'b0;
    bus.lkp_inst  = '0;
    bus.lkp_cond  = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_inst  = '0;
    bus.upd_taddr = '0;
    bus.upd_taken = 1'b0;
    bus.upd_cond  = 1'b0;
  endtask

  logic [ADDR_W-1:0] wr_seen[$];
  logic [4:0]        hist;
  int                nwr;
  logic [ADDR_W-1:0] wtaddr;

  initial begin
    clr_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_upd_ready", bus.upd_ready, 0);
    chk("rst_q_count", bus.q_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_btb_sel", bus.btb_sel, 0);
    chk("idle_bp_sel", bus.bp_sel, 0);
    chk("idle_q_count", bus.q_count, 0);
    chk("idle_upd_ready", bus.upd_ready, 1);

    // lookup on an empty queue
    bus.lkp_req = 1'b1; bus.lkp_inst = 24'h00ABCD; bus.lkp_cond = 1'b1;
    @(negedge clk);
    chk("lkp_gnt", bus.lkp_gnt, 1);
    chk("lkp_rd_wr", bus.btb_rd_wr, 1);
    chk("lkp_lht", bus.bp_lht_index, 5'h0D);
    chk("lkp_bp_sel", bus.bp_sel, 1);
    chk("lkp_inst", bus.btb_inst, 24'h00ABCD);
    chk("lkp_taddr", bus.btb_taddr, 0);
    bus.lkp_req = 1'b0;
    @(negedge clk);
    chk("lkp_drop_gnt", bus.lkp_gnt, 0);

    // single update with fetch idle
    bus.upd_valid = 1'b1; bus.upd_inst = 24'h000123; bus.upd_taddr = 32'h40;
    bus.upd_taken = 1'b1; bus.upd_cond = 1'b0;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    chk("upd_queued", bus.q_count, 1);
    chk("upd_no_bypass", bus.btb_sel, 0);
    @(negedge clk);
    chk("upd_sel", bus.btb_sel, 1);
    chk("upd_rd_wr", bus.btb_rd_wr, 0);
    chk("upd_taddr", bus.btb_taddr, 32'h40);
    chk("upd_inst", bus.btb_inst, 24'h000123);
    chk("upd_taken", bus.bp_taken, 1);
    chk("upd_lht", bus.bp_lht_index, 5'h03);
    chk("upd_bp_rd_wr", bus.bp_rd_wr, 0);
    chk("upd_drained", bus.q_count, 0);
    @(negedge clk);
    chk("upd_after_idle", bus.btb_sel, 0);

    // starvation: lookups held high while one update waits
    bus.lkp_req = 1'b1; bus.lkp_inst = 24'h000055; bus.lkp_cond = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_inst = 24'h000777; bus.upd_taddr = 32'h80;
    bus.upd_taken = 1'b0; bus.upd_cond = 1'b1;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    chk("starve_first_lkp", bus.lkp_gnt, 1);
    chk("starve_queued", bus.q_count, 1);
    hist = '0; nwr = 0; wtaddr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hist = {hist[3:0], bus.lkp_gnt};
      if (bus.btb_sel && !bus.btb_rd_wr) begin
        nwr++;
        wtaddr = bus.btb_taddr;
      end
    end
    chk("starve_pattern", hist, 5'b11101);
    chk("starve_writes", nwr, 1);
    chk("starve_taddr", wtaddr, 32'h80);

    // overfill with lookups held: fifth push refused, order preserved
    wr_seen.delete();
    for (int i = 0; i < 5; i++) begin
      bus.upd_valid = 1'b1;
      bus.upd_inst  = 24'h000200 + 24'(i);
      bus.upd_taddr = 32'h100 + 32'(4 * i);
      bus.upd_taken = (i % 2 == 1);
      bus.upd_cond  = 1'b1;
      @(negedge clk);
      if (bus.btb_sel && !bus.btb_rd_wr) wr_seen.push_back(bus.btb_taddr);
      if (i == 3) begin
        chk("full_count", bus.q_count, 4);
        chk("full_ready", bus.upd_ready, 0);
      end
      if (i == 4) chk("full_forced_upd", bus.btb_rd_wr, 0);
    end
    bus.upd_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.btb_sel && !bus.btb_rd_wr) wr_seen.push_back(bus.btb_taddr);
    end
    chk("fifo_nwr", wr_seen.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("fifo_order", (i < wr_seen.size()) ? wr_seen[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));

    // reset with three updates pending
    for (int i = 0; i < 3; i++) begin
      bus.upd_valid = 1'b1;
      bus.upd_taddr = 32'h900 + 32'(i);
      bus.upd_inst  = 24'h000900 + 24'(i);
      @(negedge clk);
    end
    bus.upd_valid = 1'b0;
    chk("rst_pre_count", bus.q_count, 3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_count", bus.q_count, 0);
    chk("rst_mid_sel", bus.btb_sel, 0);
    chk("rst_mid_bp_sel", bus.bp_sel, 0);
    chk("rst_mid_gnt", bus.lkp_gnt, 0);
    chk("rst_mid_rd_wr", bus.btb_rd_wr, 1);
    chk("rst_mid_ready", bus.upd_ready, 0);
    rst = 1'b1;
    bus.lkp_req = 1'b0;
    nwr = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.btb_sel) nwr++;
    end
    chk("no_stale_write", nwr, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.lkp_req   = ($urandom_range(0, 99) < 65);
      bus.lkp_inst  = 24'($urandom);
      bus.lkp_cond  = 1'($urandom);
      bus.upd_valid = ($urandom_range(0, 99) < 45);
      bus.upd_inst  = 24'($urandom);
      bus.upd_taddr = $urandom;
      bus.upd_taken = 1'($urandom);
      bus.upd_cond  = 1'($urandom);
      rst           = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    clr_inputs();
    repeat (6) @(negedge clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
